harmonic_voice: RTL
===================

# harmonic_voice

Parametrised additive-synthesis voice: the successor to the fixed-configuration harmonics generator. It sums `N_HARM` harmonics of one phase accumulator, each read from a shared quarter-wave sine table and weighted per instrument. A linear release envelope replaces the hard mute. It sits between the note sequencer (step size, instrument, note_done) and the audio sample path (sample_out, sample_ready), and computes one sample per request.

## Interface
- `N_HARM`, 4: harmonics summed, 1..8.
- `SAMPLE_W`, 16: signed output width.
- `STEP_W`, 20: step_size width.
- `PHASE_W`, 22: phase accumulator width; must be ≥ STEP_W and ≥ ROM_AW+2.
- `ROM_AW`, 8: quarter-wave table address width (2^(ROM_AW+2) points per cycle).
- `RELEASE_STEP`, 64: envelope decrement per sample while releasing, 1..256.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `play_enable` in 1: voice enable.
- `generate_next_sample` in 1: sample request level; rising edge starts a sample.
- `step_size` in STEP_W: phase increment per sample, unsigned.
- `instrument` in 2: weight-table select.
- `note_done` in 1: level, high = release.
- `sample_out` out SAMPLE_W: signed sample, held until the next sample.
- `sample_ready` out 1: one-cycle pulse when sample_out updates.

## Operation
- **Sine function.** sin(k) = round((2^(SAMPLE_W-1)-1)·sin(2πk/2^(ROM_AW+2))). It uses quarter-wave symmetry from a single table.
- **Harmonic weights** (unsigned, harmonics 1..8; only the first N_HARM are used):
  - inst0: 8,0,0,0,0,0,0,0
  - inst1: 8,4,2,1,1,0,0,0
  - inst2: 8,0,3,0,2,0,1,0
  - inst3: 4,4,4,4,4,4,4,4
- **Request detection.** A rising edge of generate_next_sample is detected against a registered copy. It is honoured only in IDLE with play_enable=1. Otherwise it is dropped.
- **Start (leaving IDLE).**
  - Latch instrument and phase P.
  - Update the phase: phase ← phase + step_size, mod 2^PHASE_W.
  - Update the envelope:
    - note_done=0: env ← 256.
    - note_done=1: env ← max(env − RELEASE_STEP, 0).
- **States.**
  - IDLE → ACCUM on an honoured request.
  - ACCUM runs N_HARM cycles, harmonic h=1..N_HARM in order. Each cycle: index = top ROM_AW+2 bits of (P·h mod 2^PHASE_W); acc += w[inst][h]·sin(index).
  - ACCUM → SCALE: mix = acc >>> 3 (arithmetic), then saturate to the signed SAMPLE_W range.
  - SCALE → OUT: sample_out ← (mix·env) >>> 8; sample_ready ← 1.
  - OUT → IDLE.
- **Widths.** acc is signed, at least SAMPLE_W+7 bits, and never overflows. The envelope is 9 bits, range 0..256, so env=256 gives unity gain.
- **play_enable=0.**
  - In IDLE: phase ← 0, env ← 256, sample_out ← 0, no sample_ready.
  - In flight: the current sample completes normally.
- **Mid-sample input changes.** Changes to instrument, step_size and note_done while busy take effect at the next start.

## Timing
- **Reset values.** sample_out=0, sample_ready=0, phase=0, env=256, state IDLE, request-edge register=0. Reset aborts any in-flight sample with no sample_ready.
- **Latency.** With the request edge sampled at clock edge E0, sample_ready is high during the cycle after edge E0+N_HARM+2. That is N_HARM+2 cycles of latency.
- **Minimum request spacing** is N_HARM+3 cycles. Rising edges arriving while busy are lost and are not queued.
- **sample_ready** is exactly one cycle wide. sample_out is stable from that cycle until the next OUT.
- **First sample after reset or enable** uses P=0, so the output is 0.
- **Simultaneous events.** note_done rising in the same cycle as an honoured request applies the decrement at that start. Once env=0, every output is exactly 0.

## Test plan
Default parameters, step_size=524288 (1/8 cycle), note_done=0, unless stated otherwise.

1. **Reset and latency.** Hold reset, then release it with play_enable=1 and inst0, and issue a request. Required: sample_out=0 during reset. sample_ready pulses once, 6 cycles after the edge, with sample 0.
2. **inst0.** Three successive requests. Required: samples 0, 23170, 32767.
3. **Harmonic mixing.** inst1, third sample (P = quarter cycle). Required: 24575. inst2 at the same phase. Required: (8·32767 − 3·32767)>>>3 = 20479.
4. **Saturation.** inst3, second sample (P = 1/8 cycle). Required: the raw 39553 clamps to 32767.
5. **Release.** inst0, step_size=1048575. Assert note_done=1 for 5 requests. Required: env sequence 192, 128, 64, 0, 0. The fourth and fifth samples are exactly 0. Deassert note_done. Required: the next sample returns to full amplitude.
6. **Dropped requests and disable.** A request 2 cycles after a previous one. Required: ignored, a single sample_ready. play_enable=0 with requests. Required: no sample_ready, sample_out=0, and the phase restarts at 0 on re-enable.

Source files
------------

// File: rtl/harmonic_voice.sv
// Additive-synthesis voice: sums N_HARM weighted harmonics of one phase accumulator,
// read from a shared quarter-wave sine table, then applies a linear release envelope.
module harmonic_voice #(
    parameter int N_HARM       = 4,
    parameter int SAMPLE_W     = 16,
    parameter int STEP_W       = 20,
    parameter int PHASE_W      = 22,
    parameter int ROM_AW       = 8,
    parameter int RELEASE_STEP = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       generate_next_sample,
    input  logic [STEP_W-1:0]          step_size,
    input  logic [1:0]                 instrument,
    input  logic                       note_done,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_ready
);
    localparam int  ACC_W = SAMPLE_W + 7;
    localparam int  IDX_W = ROM_AW + 2;
    localparam int  ROM_N = (1 << ROM_AW) + 1;
    localparam int  AMP   = (1 << (SAMPLE_W - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;

    localparam logic [ROM_AW:0]              QUARTER = (ROM_AW + 1)'(1 << ROM_AW);
    localparam logic [8:0]                   REL     = 9'(RELEASE_STEP);
    localparam logic signed [ACC_W-1:0]      MAX_V   = ACC_W'(AMP);
    localparam logic signed [ACC_W-1:0]      MIN_V   = ACC_W'(-AMP - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                      state_r;
    logic                        req_d_r;
    logic [PHASE_W-1:0]          phase_r;
    logic [PHASE_W-1:0]          p_lat_r;
    logic [8:0]                  env_r;
    logic [1:0]                  inst_r;
    logic [3:0]                  h_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic signed [SAMPLE_W-1:0]  mix_r;

    logic [SAMPLE_W-2:0]         rom [0:ROM_N-1];
    logic [PHASE_W-1:0]          ph_s;
    logic [IDX_W-1:0]            idx_s;
    logic [ROM_AW:0]             addr_s;
    logic [SAMPLE_W-2:0]         mag_s;
    logic signed [SAMPLE_W-1:0]  sin_s;
    logic signed [SAMPLE_W+4:0]  term_s;
    logic signed [ACC_W-1:0]     shifted_s;
    logic signed [SAMPLE_W-1:0]  mix_s;
    logic signed [SAMPLE_W+9:0]  scaled_s;
    logic [8:0]                  env_dec_s;

    // Weight rows pack harmonic 1 in the top nibble down to harmonic 8 in the bottom one.
    function automatic logic [3:0] weight(input logic [1:0] inst, input logic [3:0] h);
        logic [31:0] row;
        case (inst)
            2'd0:    row = 32'h8000_0000;
            2'd1:    row = 32'h8421_1000;
            2'd2:    row = 32'h8030_2010;
            2'd3:    row = 32'h4444_4444;
            default: row = 32'h0000_0000;
        endcase
        return 4'(row >> (6'd32 - {h, 2'b00}));
    endfunction

    // First quadrant plus the pi/2 endpoint, evaluated at elaboration by a Taylor series.
    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        localparam real X  = PI * real'(k) / real'(2 << ROM_AW);
        localparam real X2 = X * X;
        localparam real S  = X * (1.0 - X2 / 6.0 * (1.0 - X2 / 20.0 * (1.0 - X2 / 42.0 *
                             (1.0 - X2 / 72.0 * (1.0 - X2 / 110.0 * (1.0 - X2 / 156.0 *
                             (1.0 - X2 / 210.0)))))));
        localparam int  V  = $rtoi(real'(AMP) * S + 0.5);
        assign rom[k] = (SAMPLE_W - 1)'(V);
    end

    assign ph_s      = p_lat_r * PHASE_W'(h_r);
    assign idx_s     = IDX_W'(ph_s >> (PHASE_W - IDX_W));
    assign addr_s    = idx_s[ROM_AW] ? (QUARTER - {1'b0, idx_s[ROM_AW-1:0]})
                                     : {1'b0, idx_s[ROM_AW-1:0]};
    assign mag_s     = rom[addr_s];
    assign sin_s     = idx_s[IDX_W-1] ? -$signed({1'b0, mag_s}) : $signed({1'b0, mag_s});
    assign term_s    = (SAMPLE_W + 5)'($signed({1'b0, weight(inst_r, h_r)}))
                     * (SAMPLE_W + 5)'(sin_s);
    assign shifted_s = acc_r >>> 3;
    assign scaled_s  = (SAMPLE_W + 10)'(mix_r) * (SAMPLE_W + 10)'($signed({1'b0, env_r}));

    // Saturate the attenuated mix to the signed sample range and compute the release step.
    always_comb begin
        mix_s     = '0;
        env_dec_s = 9'd0;
        if (shifted_s > MAX_V) begin
            mix_s = SAMPLE_W'(MAX_V);
        end else if (shifted_s < MIN_V) begin
            mix_s = SAMPLE_W'(MIN_V);
        end else begin
            mix_s = SAMPLE_W'(shifted_s);
        end
        if (env_r > REL) begin
            env_dec_s = env_r - REL;
        end else begin
            env_dec_s = 9'd0;
        end
    end

    // Sample sequencer: IDLE -> ACCUM (one harmonic per cycle) -> SCALE -> OUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            req_d_r      <= 1'b0;
            phase_r      <= '0;
            p_lat_r      <= '0;
            env_r        <= 9'd256;
            inst_r       <= 2'd0;
            h_r          <= 4'd0;
            acc_r        <= '0;
            mix_r        <= '0;
            sample_out   <= '0;
            sample_ready <= 1'b0;
        end else begin
            req_d_r      <= generate_next_sample;
            sample_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!play_enable) begin
                        phase_r    <= '0;
                        env_r      <= 9'd256;
                        sample_out <= '0;
                    end else if (generate_next_sample && !req_d_r) begin
                        p_lat_r <= phase_r;
                        inst_r  <= instrument;
                        phase_r <= phase_r + PHASE_W'(step_size);
                        env_r   <= note_done ? env_dec_s : 9'd256;
                        acc_r   <= '0;
                        h_r     <= 4'd1;
                        state_r <= ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    acc_r <= acc_r + ACC_W'(term_s);
                    if (h_r == 4'(N_HARM)) begin
                        state_r <= SCALE;
                    end else begin
                        h_r <= h_r + 4'd1;
                    end
                end
                SCALE: begin
                    mix_r   <= mix_s;
                    state_r <= OUT;
                end
                OUT: begin
                    sample_out   <= SAMPLE_W'(scaled_s >>> 8);
                    sample_ready <= 1'b1;
                    state_r      <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule
